// File: rtl/decn_pkg.sv
// Shared definitions for the decn_scan decoder/scanner: Mode encodings and
// a helper that sizes the scan divider counter.
package decn_pkg;

  typedef enum logic [1:0] {
    MODE_DEC   = 2'b00,
    MODE_THERM = 2'b01,
    MODE_SCAN  = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  // Counter width for a divider that counts 0..div-1 (at least one bit so a
  // divide-by-one still has a legal vector).
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/decn_scan_if.sv
// Bus bundle for decn_scan: control inputs (En, Mode, W) and registered
// outputs (Y, Idx, Tick). There is no handshake on this bus: the master
// drives En/Mode/W continuously and the block samples them on every rising
// clock edge; Y/Idx/Tick are valid every cycle, one edge after the sample.
interface decn_scan_if #(
  parameter int N = 3
) ();

  logic              En;
  logic [1:0]        Mode;
  logic [N-1:0]      W;
  logic [2**N-1:0]   Y;
  logic [N-1:0]      Idx;
  logic              Tick;

  modport master (output En, Mode, W, input Y, Idx, Tick);
  modport slave  (input En, Mode, W, output Y, Idx, Tick);

endinterface

// File: rtl/decn_scan_timer.sv
// Scan step divider: counts 0..TICK_DIV-1 while En is high and strobes Tick
// (combinationally) on the cycle the count wraps. Clr reloads zero without
// a strobe and wins over En.
module scan_timer
  import decn_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic En,
  input  logic Clr,
  output logic Tick
);

  localparam int            CW   = cnt_width(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count and wrap strobe.
  always_comb begin
    cnt_d = cnt_q;
    Tick  = 1'b0;
    if (Clr) begin
      cnt_d = '0;
    end else if (En) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        Tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge Clock) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/decn_scan.sv
// decn_scan: registered N-to-2**N decoder with decode, thermometer and
// timed scan modes. Build macro DECN_SCAN_ACTLOW_EN makes Y active-low
// (common-anode drive); Idx and Tick keep their polarity either way.
module decn_scan
  import decn_pkg::*;
#(
  parameter int N        = 3,
  parameter int TICK_DIV = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  decn_scan_if.slave  bus
);

  localparam int YW = 2**N;

`ifdef DECN_SCAN_ACTLOW_EN
  localparam logic [YW-1:0] Y_POL = '1;
`else
  localparam logic [YW-1:0] Y_POL = '0;
`endif

  logic [YW-1:0] y_q, y_d, y_act;
  logic [N-1:0]  idx_q, idx_d;
  logic          tick_q, tick_d;
  // Remembers whether the last enabled cycle was in scan mode, so a switch
  // into scan (or the first scan cycle after reset) restarts the scan.
  logic          in_scan_q, in_scan_d;
  logic          scan_en, enter, step;

  assign scan_en = bus.En && (bus.Mode == MODE_SCAN);
  assign enter   = scan_en && !in_scan_q;

  scan_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .Clock (Clock),
    .Reset (Reset),
    .En    (scan_en && !enter),
    .Clr   (enter),
    .Tick  (step)
  );

  // Scan index stepping, tick, and the decoded output pattern.
  always_comb begin
    idx_d     = idx_q;
    tick_d    = step;
    in_scan_d = bus.En ? (bus.Mode == MODE_SCAN) : in_scan_q;
    y_act     = '0;
    if (enter) begin
      idx_d = '0;
    end else if (step) begin
      idx_d = (idx_q >= bus.W) ? '0 : idx_q + N'(1);
    end
    if (bus.En) begin
      case (mode_e'(bus.Mode))
        MODE_DEC:   y_act[bus.W] = 1'b1;
        MODE_THERM: begin
          for (int i = 0; i < YW; i++) y_act[i] = (i <= int'(bus.W));
        end
        MODE_SCAN:  y_act[idx_d] = 1'b1;
        default:    y_act = '0;
      endcase
    end
    y_d = y_act ^ Y_POL;
  end

  // Output and scan-state registers; reset idles Y at its inactive level.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      y_q       <= Y_POL;
      idx_q     <= '0;
      tick_q    <= 1'b0;
      in_scan_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      idx_q     <= idx_d;
      tick_q    <= tick_d;
      in_scan_q <= in_scan_d;
    end
  end

  assign bus.Y    = y_q;
  assign bus.Idx  = idx_q;
  assign bus.Tick = tick_q;

endmodule

// File: tb/tb_decn_scan.sv
// Directed bench for decn_scan (N=3, TICK_DIV=4). Each driven cycle pushes
// its hand-computed {Y, Idx, Tick} into exp_q; a monitor on the falling edge
// pops and compares after the rising edge that produced the outputs.
module tb_decn_scan;
  import decn_pkg::*;

  localparam int N  = 3;
  localparam int TD = 4;

`ifdef DECN_SCAN_ACTLOW_EN
  localparam logic [7:0] YINV = 8'hFF;
`else
  localparam logic [7:0] YINV = 8'h00;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decn_scan_if #(.N(N)) bus ();

  decn_scan #(.N(N), .TICK_DIV(TD)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  string       name_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic en, input logic [1:0] m,
                      input logic [2:0] w, input logic [7:0] ey,
                      input logic [2:0] ei, input logic et, input string nm);
    @(negedge clk);
    #1;
    rst      = r;
    bus.En   = en;
    bus.Mode = m;
    bus.W    = w;
    exp_q.push_back({ey ^ YINV, ei, et});
    name_q.push_back(nm);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [11:0] e;
      logic [11:0] got;
      string       nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {bus.Y, bus.Idx, bus.Tick};
      n_vec++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got Y=%h Idx=%0d Tick=%b, want Y=%h Idx=%0d Tick=%b",
                 nm, got[11:4], got[3:1], got[0], e[11:4], e[3:1], e[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] ix;
    bus.En   = 1'b0;
    bus.Mode = MODE_DEC;
    bus.W    = '0;

    // Reset, including priority over En/Mode.
    step(1, 0, MODE_DEC,  0, 8'h00, 0, 0, "reset");
    step(1, 1, MODE_SCAN, 3, 8'h00, 0, 0, "reset_prio");

    // Decode sweep W=0..7.
    for (int w = 0; w < 8; w++)
      step(0, 1, MODE_DEC, 3'(w), 8'h01 << w, 0, 0, "decode");

    // Thermometer.
    step(0, 1, MODE_THERM, 0, 8'h01, 0, 0, "therm_w0");
    step(0, 1, MODE_THERM, 3, 8'h0F, 0, 0, "therm_w3");
    step(0, 1, MODE_THERM, 7, 8'hFF, 0, 0, "therm_w7");
    step(0, 1, MODE_THERM, 5, 8'h3F, 0, 0, "therm_w5");

    // Reserved mode and disable.
    step(0, 1, MODE_RSVD, 5, 8'h00, 0, 0, "rsvd");
    step(0, 0, MODE_DEC,  2, 8'h00, 0, 0, "disable_dec");

    // Scan W=2: entry, then Idx 0,1,2,0,1 with a Tick every 4 clocks.
    step(0, 1, MODE_SCAN, 2, 8'h01, 0, 0, "scan_enter");
    for (int k = 1; k <= 16; k++) begin
      ix = 3'((k / 4) % 3);
      step(0, 1, MODE_SCAN, 2, 8'h01 << ix, ix, (k % 4) == 0, "scan_w2");
    end

    // Widen to W=7 and run up to Idx 5.
    for (int k = 1; k <= 16; k++) begin
      ix = 3'(1 + k / 4);
      step(0, 1, MODE_SCAN, 7, 8'h01 << ix, ix, (k % 4) == 0, "scan_w7");
    end

    // Drop W to 3 at Idx 5: Idx holds until the next step, then wraps.
    step(0, 1, MODE_SCAN, 3, 8'h20, 5, 0, "w_drop_hold");
    step(0, 1, MODE_SCAN, 3, 8'h20, 5, 0, "w_drop_hold");
    for (int k = 0; k < 10; k++)
      step(0, 0, MODE_SCAN, 3, 8'h00, 5, 0, "en_low_freeze");
    step(0, 1, MODE_SCAN, 3, 8'h20, 5, 0, "resume_count");
    step(0, 1, MODE_SCAN, 3, 8'h01, 0, 1, "w_drop_wrap");

    // Run to Idx 4 with W=7, then reset mid-scan.
    for (int k = 1; k <= 16; k++) begin
      ix = 3'(k / 4);
      step(0, 1, MODE_SCAN, 7, 8'h01 << ix, ix, (k % 4) == 0, "scan_to4");
    end
    step(0, 1, MODE_SCAN, 7, 8'h10, 4, 0, "at_idx4");
    step(1, 1, MODE_SCAN, 7, 8'h00, 0, 0, "mid_scan_reset");
    step(0, 1, MODE_SCAN, 7, 8'h01, 0, 0, "post_reset_enter");
    step(0, 1, MODE_SCAN, 7, 8'h01, 0, 0, "post_reset_wait");
    step(0, 1, MODE_SCAN, 7, 8'h01, 0, 0, "post_reset_wait");
    step(0, 1, MODE_SCAN, 7, 8'h01, 0, 0, "post_reset_wait");
    step(0, 1, MODE_SCAN, 7, 8'h02, 1, 1, "post_reset_tick");

    // Leave scan: Idx holds, Tick stays low.
    step(0, 1, MODE_DEC, 6, 8'h40, 1, 0, "idx_hold_dec");

    // Scan with W=0: Idx pinned at 0, Tick still every 4 clocks.
    step(0, 1, MODE_SCAN, 0, 8'h01, 0, 0, "scan_w0_enter");
    for (int k = 1; k <= 8; k++)
      step(0, 1, MODE_SCAN, 0, 8'h01, 0, (k % 4) == 0, "scan_w0");
    step(0, 1, MODE_RSVD, 0, 8'h00, 0, 0, "rsvd_after_scan");
    step(0, 1, MODE_DEC,  1, 8'h02, 0, 0, "decode_w1");
    step(1, 0, MODE_DEC,  0, 8'h00, 0, 0, "final_reset");

    // Drain: the last expectation must be consumed within a bounded time.
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
